// File: rtl/i2s_tdm_xcvr.sv
// i2s_tdm_xcvr: I2S/TDM audio transceiver. Derives sclk/lrck from mclk,
// deserialises NUM_CH slots from sdi into rx_data and serialises tx_data
// frames onto sdo, with a one-deep tx holding register and underrun flag.
// Ports: mclk/rst (async, active-high); tx_data/tx_vld/tx_rdy (frame in,
// ch0 in low bits); rx_data/rx_vld (frame out, one-cycle pulse); underrun;
// lrck/sclk/sdo (registered serial outputs); sdi (serial in).
// Option: define I2S_XCVR_LOOPBACK_EN to add the loopback input (after sdi)
// which makes the receiver shift from the internal sdo register.
module i2s_tdm_xcvr #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int NUM_CH   = 2,
    parameter int MCLK_DIV = 4,
    parameter int TDM      = 0
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] tx_data,
    input  logic                     tx_vld,
    output logic                     tx_rdy,
    output logic [NUM_CH*DATA_W-1:0] rx_data,
    output logic                     rx_vld,
    output logic                     underrun,
    output logic                     lrck,
    output logic                     sclk,
    input  logic                     sdi,
`ifdef I2S_XCVR_LOOPBACK_EN
    input  logic                     loopback,
`endif
    output logic                     sdo
);
    localparam int FRAME = NUM_CH * SLOT_W;
    localparam int TW    = NUM_CH * DATA_W;
    localparam int DCW   = $clog2(MCLK_DIV);
    localparam int PW    = $clog2(FRAME);
    localparam int IW    = $clog2(TW);

    localparam logic [DCW-1:0] DIV_LAST = DCW'(MCLK_DIV - 1);
    localparam logic [DCW-1:0] DIV_HALF = DCW'(MCLK_DIV / 2);
    localparam logic [PW-1:0]  P_LAST   = PW'(FRAME - 1);

    logic [DCW-1:0] div_cnt;
    logic [DCW-1:0] div_nxt;
    logic [PW-1:0]  pos;
    logic [PW-1:0]  pos_nxt;
    logic           fall;
    logic           rise;
    logic           frame_start;
    logic           accept;
    logic           starve;
    logic           rx_last;
    logic           rx_bit;
    logic           sdo_nxt;
    logic           lrck_nxt;
    logic           hold_full;
    logic           primed;
    logic [TW-1:0]  hold;
    logic [TW-1:0]  tx_frame;
    logic [TW-1:0]  tx_src;
    logic [TW-1:0]  rx_buf;
    logic [TW-1:0]  rx_buf_nxt;
    logic [IW-1:0]  tx_idx;
    logic [IW-1:0]  rx_idx;
    int             tx_ch;
    int             tx_b;
    int             rx_ch;
    int             rx_b;

    assign fall        = (div_cnt == DIV_LAST);
    assign rise        = (div_cnt == DIV_HALF);
    assign div_nxt     = fall ? '0 : div_cnt + 1'b1;
    assign pos_nxt     = (pos == P_LAST) ? '0 : pos + 1'b1;
    assign frame_start = fall && (pos == '0);
    assign accept      = tx_vld && !hold_full;
    assign rx_last     = rise && (pos == P_LAST);
    assign tx_rdy      = ~hold_full;

`ifdef I2S_XCVR_LOOPBACK_EN
    assign rx_bit = loopback ? sdo : sdi;
`else
    assign rx_bit = sdi;
`endif

    // Outputs are computed for the position being entered (pos_nxt);
    // the receiver works on the current position.
    always_comb begin
        tx_ch  = int'(pos_nxt) / SLOT_W;
        tx_b   = int'(pos_nxt) % SLOT_W;
        rx_ch  = int'(pos) / SLOT_W;
        rx_b   = int'(pos) % SLOT_W;
        starve = 1'b0;
        tx_src = tx_frame;
        // Frame start: pending word first, else a same-cycle accept
        // bypasses the holding register, else send silence.
        if (frame_start) begin
            if (hold_full) begin
                tx_src = hold;
            end else if (accept) begin
                tx_src = tx_data;
            end else begin
                tx_src = '0;
                starve = 1'b1;
            end
        end
        // Slot bit b (1..DATA_W) carries sample bit DATA_W-b.
        tx_idx  = IW'(tx_ch * DATA_W + DATA_W - tx_b);
        sdo_nxt = 1'b0;
        if (tx_b >= 1 && tx_b <= DATA_W) begin
            sdo_nxt = tx_src[tx_idx];
        end
        lrck_nxt = (TDM != 0) ? (pos_nxt == '0) : tx_ch[0];
        rx_idx     = IW'(rx_ch * DATA_W + DATA_W - rx_b);
        rx_buf_nxt = rx_buf;
        if (rise && rx_b >= 1 && rx_b <= DATA_W) begin
            rx_buf_nxt[rx_idx] = rx_bit;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            pos       <= '0;
            sclk      <= 1'b0;
            lrck      <= 1'b0;
            sdo       <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx_frame  <= '0;
            underrun  <= 1'b0;
            rx_buf    <= '0;
            rx_data   <= '0;
            rx_vld    <= 1'b0;
            primed    <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            sclk     <= (div_nxt >= DIV_HALF);
            underrun <= starve;
            rx_buf   <= rx_buf_nxt;
            rx_vld   <= rx_last && primed;
            if (fall) begin
                pos  <= pos_nxt;
                lrck <= lrck_nxt;
                sdo  <= sdo_nxt;
            end
            if (frame_start) begin
                tx_frame  <= tx_src;
                hold_full <= 1'b0;
            end else if (accept) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
            // The frame in flight at reset release is not published.
            if (rx_last) begin
                primed <= 1'b1;
                if (primed) begin
                    rx_data <= rx_buf_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tdm_xcvr.sv
// tb_i2s_tdm_xcvr: directed/random bench for i2s_tdm_xcvr (I2S default
// instance plus a 4-slot TDM instance) against a timeline model.
module tb_i2s_tdm_xcvr;
    localparam int DW  = 24;
    localparam int SW  = 32;
    localparam int NC  = 2;
    localparam int TW  = NC * DW;
    localparam int FR  = NC * SW;
    localparam int FM  = FR * 4;
    localparam int FM4 = 4 * SW * 4;

    logic          mclk    = 1'b0;
    logic          rst     = 1'b1;
    logic [TW-1:0] tx_data = '0;
    logic          tx_vld  = 1'b0;
    logic          sdi     = 1'b0;
    logic          lb      = 1'b0;
    logic          tx_rdy, rx_vld, underrun, lrck, sclk, sdo;
    logic [TW-1:0] rx_data;
    logic [4*DW-1:0] t_rx;
    logic          t_rdy, t_vld, t_und, t_lrck, t_sclk, t_sdo;

    i2s_tdm_xcvr u_dut (
        .mclk(mclk), .rst(rst), .tx_data(tx_data), .tx_vld(tx_vld),
        .tx_rdy(tx_rdy), .rx_data(rx_data), .rx_vld(rx_vld),
        .underrun(underrun), .lrck(lrck), .sclk(sclk), .sdi(sdi),
`ifdef I2S_XCVR_LOOPBACK_EN
        .loopback(lb),
`endif
        .sdo(sdo)
    );

    i2s_tdm_xcvr #(.NUM_CH(4), .TDM(1)) u_tdm (
        .mclk(mclk), .rst(rst), .tx_data('0), .tx_vld(1'b0),
        .tx_rdy(t_rdy), .rx_data(t_rx), .rx_vld(t_vld),
        .underrun(t_und), .lrck(t_lrck), .sclk(t_sclk), .sdi(1'b0),
`ifdef I2S_XCVR_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .sdo(t_sdo)
    );

    always #5 mclk = ~mclk;

    int            vectors     = 0;
    int            miscompares = 0;
    int            k           = 0;
    logic [TW-1:0] tx_fr [0:15];
    logic [TW-1:0] rx_fr [0:15];
    bit            lbf   [0:15];
    logic [TW-1:0] pend  [$];
    bit            und_n = 1'b0;

    function automatic logic bit_of(logic [TW-1:0] fr, int p);
        logic [DW-1:0] smp;
        int b;
        b   = p % SW;
        smp = fr[(p / SW) * DW +: DW];
        if (b >= 1 && b <= DW) return smp[DW - b];
        return 1'b0;
    endfunction

    task automatic check_reset(string tag);
        logic [11:0] got;
        got = {sclk, lrck, sdo, rx_vld, underrun, tx_rdy,
               t_sclk, t_lrck, t_sdo, t_vld, t_und, t_rdy};
        vectors++;
        assert (got === 12'b000001_000001 && rx_data === '0 && t_rx === '0)
        else begin
            miscompares++;
            $error("FAIL %s got %b rx %h exp 000001000001 rx 0", tag, got, rx_data);
        end
    endtask

    task automatic check_cycle();
        int p, f, pt;
        logic [11:0] got, exp_v;
        logic [TW-1:0] exp_rx;
        p  = (k / 4) % FR;
        f  = k / FM;
        pt = (k / 4) % (4 * SW);
        exp_v = {(k % 4) >= 2, (p / SW) % 2 == 1, bit_of(tx_fr[f], p),
                 (k % FM == FM - 1) && f >= 1, und_n, pend.size() == 0,
                 (k % 4) >= 2, pt == 0 && k >= FM4, 1'b0,
                 (k % FM4 == FM4 - 1) && k >= FM4, k % FM4 == 4, 1'b1};
        got = {sclk, lrck, sdo, rx_vld, underrun, tx_rdy,
               t_sclk, t_lrck, t_sdo, t_vld, t_und, t_rdy};
        vectors++;
        assert (got === exp_v)
        else begin
            miscompares++;
            $error("FAIL pins k=%0d got %b exp %b", k, got, exp_v);
        end
        if (exp_v[8]) begin
            exp_rx = lbf[f] ? tx_fr[f] : rx_fr[f];
            vectors++;
            assert (rx_data === exp_rx)
            else begin
                miscompares++;
                $error("FAIL rx_data k=%0d got %h exp %h", k, rx_data, exp_rx);
            end
        end
        if (exp_v[2]) begin
            vectors++;
            assert (t_rx === '0)
            else begin
                miscompares++;
                $error("FAIL tdm_rx k=%0d got %h exp 0", k, t_rx);
            end
        end
    endtask

    // Model one mclk edge: frame N's tx word is fixed at edge N*FM+4.
    task automatic step(output bit acc);
        int nf;
        if (k % FM == 0) lbf[k / FM] = lb;
        acc   = tx_vld && (pend.size() == 0);
        und_n = 1'b0;
        nf    = (k + 1) / FM;
        if ((k + 1) % FM == 4) begin
            if (pend.size() != 0) begin
                tx_fr[nf] = pend.pop_front();
            end else if (acc) begin
                tx_fr[nf] = tx_data;
            end else begin
                tx_fr[nf] = '0;
                und_n     = 1'b1;
            end
        end else if (acc) begin
            pend.push_back(tx_data);
        end
        @(posedge mclk);
        k++;
        @(negedge mclk);
        check_cycle();
        sdi = bit_of(rx_fr[k / FM], (k / 4) % FR);
    endtask

    task automatic offer(logic [TW-1:0] d);
        bit acc;
        int n;
        acc     = 1'b0;
        n       = 0;
        tx_data = d;
        tx_vld  = 1'b1;
        while (!acc && n < 2 * FM + 8) begin
            step(acc);
            n++;
        end
        tx_vld = 1'b0;
        vectors++;
        assert (acc)
        else begin
            miscompares++;
            $error("FAIL offer_timeout got %0d cycles exp accept", n);
        end
    endtask

    task automatic idle_to(int target);
        bit acc;
        while (k < target) step(acc);
    endtask

    task automatic release_rst();
        @(negedge mclk);
        rst   = 1'b0;
        k     = 0;
        und_n = 1'b0;
        pend.delete();
        for (int i = 0; i < 16; i++) begin
            rx_fr[i] = TW'({$urandom(), $urandom()});
            lbf[i]   = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tx_fr[i] = '0;
        #12;
        check_reset("reset");
        release_rst();
        rx_fr[1] = {24'hABCDEF, 24'h123456};
        offer({24'h7FFFFE, 24'h800001});
        offer(TW'({$urandom(), $urandom()}));
        offer(TW'({$urandom(), $urandom()}));
        idle_to(FM * 4 + 3);
        offer(TW'({$urandom(), $urandom()}));
        idle_to(FM * 5 + 8);
        offer(TW'({$urandom(), $urandom()}));
        idle_to(FM * 5 + 40 * 4);
        #2 rst = 1'b1;
        #1 check_reset("mid_reset");
        release_rst();
        idle_to(FM * 2 + 8);
`ifdef I2S_XCVR_LOOPBACK_EN
        idle_to(FM * 3);
        lb = 1'b1;
        offer(TW'({$urandom(), $urandom()}));
        offer(TW'({$urandom(), $urandom()}));
        idle_to(FM * 6);
        lb = 1'b0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
